// File: rtl/pipe_adder.sv
// Chunked, valid/ready pipelined adder/subtractor.
// One CHUNK-bit slice per stage, with operand skew and sum deskew.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LAT = WIDTH / CHUNK;

  logic [WIDTH-1:0] bx;
  logic             c0;
  logic             adv;
  logic             last_vld;
  logic             last_cy;
  logic             last_ovf;
  logic [WIDTH-1:0] last_sum;

  assign bx        = sub ? ~b : b;
  assign c0        = cin ^ sub;
  assign adv       = !last_vld || out_ready;
  assign in_ready  = adv;
  assign out_valid = last_vld;
  assign s         = last_sum;
  assign cout      = last_cy;
  assign ovf       = last_ovf;

  for (genvar k = 0; k < LAT; k++) begin : stg
    localparam int SW = (k + 1) * CHUNK;

    logic [CHUNK-1:0] oa;
    logic [CHUNK-1:0] ob;
    logic             ci;
    logic             vin;
    logic [CHUNK:0]   t;
    logic [SW-1:0]    sum_n;
    logic [SW-1:0]    sum;
    logic             vld;
    logic             cy;

    if (k == 0) begin : g_in
      assign oa    = a[CHUNK-1:0];
      assign ob    = bx[CHUNK-1:0];
      assign ci    = c0;
      assign vin   = in_valid;
      assign sum_n = t[CHUNK-1:0];
    end else begin : g_in
      assign oa    = stg[k-1].g_hi.ha[CHUNK-1:0];
      assign ob    = stg[k-1].g_hi.hb[CHUNK-1:0];
      assign ci    = stg[k-1].cy;
      assign vin   = stg[k-1].vld;
      assign sum_n = {t[CHUNK-1:0], stg[k-1].sum};
    end

    assign t = {1'b0, oa} + {1'b0, ob}
             + {{CHUNK{1'b0}}, ci};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        cy  <= 1'b0;
        sum <= '0;
      end else if (adv) begin
        vld <= vin;
        cy  <= t[CHUNK];
        sum <= sum_n;
      end
    end

    if (k < LAT - 1) begin : g_hi
      // Operand chunks not yet consumed ride along, LSB-aligned.
      localparam int HW = WIDTH - SW;

      logic [HW-1:0] ha;
      logic [HW-1:0] hb;
      logic [HW-1:0] ha_n;
      logic [HW-1:0] hb_n;

      if (k == 0) begin : g_src
        assign ha_n = a[WIDTH-1:CHUNK];
        assign hb_n = bx[WIDTH-1:CHUNK];
      end else begin : g_src
        assign ha_n = stg[k-1].g_hi.ha[HW+CHUNK-1:CHUNK];
        assign hb_n = stg[k-1].g_hi.hb[HW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ha <= '0;
          hb <= '0;
        end else if (adv) begin
          ha <= ha_n;
          hb <= hb_n;
        end
      end
    end else begin : g_out
      logic ov;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov <= 1'b0;
        end else if (adv) begin
          ov <= (oa[CHUNK-1] == ob[CHUNK-1])
             && (t[CHUNK-1] != oa[CHUNK-1]);
        end
      end

      assign last_vld = vld;
      assign last_cy  = cy;
      assign last_sum = sum;
      assign last_ovf = ov;
    end
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per pipeline stage. WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1.
REQ-003 The block SHALL have a derived constant LAT = WIDTH/CHUNK, the number of pipeline stages.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  input  1  — single clock; all state changes on the rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- in_valid  input  1  — the operands on this cycle are offered.
- in_ready  output  1  — the pipeline can accept an operand set this cycle.
- a  input  WIDTH  — operand A.
- b  input  WIDTH  — operand B.
- cin  input  1  — carry-in (borrow-in when sub=1).
- sub  input  1  — 0 selects add, 1 selects subtract.
- out_valid  output  1  — s, cout and ovf hold a valid result.
- out_ready  input  1  — the consumer accepts the result this cycle.
- s  output  WIDTH  — sum or difference.
- cout  output  1  — carry-out; for subtract, 1 means no borrow.
- ovf  output  1  — two's-complement signed overflow.

Function
REQ-005 The effective operand SHALL be bx = sub ? ~b : b, and the effective carry-in SHALL be c0 = cin ^ sub.
REQ-006 Results SHALL satisfy {cout, s} = a + bx + c0, computed modulo 2^(WIDTH+1).
REQ-007 ovf SHALL equal (a[WIDTH-1] == bx[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]).
REQ-008 Stage k (k = 0..LAT-1) SHALL add chunk k of a and bx, bits [k*CHUNK +: CHUNK], plus the registered carry from stage k-1; stage 0 SHALL use c0.
REQ-009 Each stage SHALL register its chunk sum and its carry.
REQ-010 Higher operand chunks SHALL be delayed (skew registers) and lower sum chunks SHALL be delayed (deskew registers), so that all bits of a result appear on s in the same cycle.
REQ-011 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-012 The pipeline SHALL advance when adv = !out_valid || out_ready.
REQ-013 in_ready SHALL equal adv, computed combinationally.
REQ-014 When adv=0, every pipeline register, including the valid bits, SHALL hold its value.
REQ-015 Latency SHALL be exactly LAT cycles. An operand set accepted at edge t SHALL make out_valid=1 with its result after edge t+LAT-1 when there is no stall. Each cycle of stall SHALL add one cycle.
REQ-016 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-017 Results SHALL leave in strict acceptance order; none SHALL be dropped or duplicated.
REQ-018 When adv=1 and in_valid=0, a bubble (valid bit 0) SHALL enter stage 0.
REQ-019 Bubbles SHALL propagate and SHALL never raise out_valid.
REQ-020 While out_valid=1 and out_ready=0, s, cout and ovf SHALL stay stable until the transfer occurs.
REQ-021 Simultaneous in and out transfers in one cycle SHALL both complete with no loss, because a full pipeline drains and refills in the same edge.
REQ-022 With CHUNK=WIDTH, the block SHALL reduce to a single-register adder with LAT=1.
REQ-023 Arithmetic SHALL wrap: a carry beyond bit WIDTH appears only on cout, with no saturation.

Reset
REQ-024 While rst_n=0, all valid bits SHALL clear immediately, independent of clk, giving out_valid=0.
REQ-025 While rst_n=0, s SHALL be 0, cout SHALL be 0, and ovf SHALL be 0.
REQ-026 While rst_n=0, in_ready SHALL be 1.
REQ-027 Operand sets in flight when rst_n falls SHALL be discarded and never emitted.
REQ-028 The first transfer after reset SHALL be accepted on the first rising edge with rst_n=1.

Verification (WIDTH=16, CHUNK=4, LAT=4)
REQ-029 Single add: a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid=1 four cycles later with s=0x0100, cout=0, ovf=0. Carry SHALL cross the chunk boundaries.
REQ-030 Subtract and wrap: a=0x0000, b=0x0001, sub=1, cin=0 -> s=0xFFFF, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
REQ-031 Full-carry stream: a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1. Back-to-back with 0x7FFF+0x0001 -> s=0x8000, ovf=1. The results SHALL appear on consecutive cycles.
REQ-032 Back-pressure: 8 consecutive inputs with out_ready low for cycles 5-7 -> in_ready=0 during the stall and outputs held stable. All 8 results SHALL arrive in order with none lost.
REQ-033 Reset mid-flight: rst_n pulsed low with 3 results in flight -> out_valid=0 immediately. No stale result SHALL appear afterwards. A new input SHALL yield the correct result LAT cycles after release.
REQ-034 Random: 10,000 random a, b, cin, sub values with random out_ready -> every result SHALL match a reference model bit-exactly and in order.
